// File: rtl/tmds_lane_encoder.sv
// Multi-lane TMDS / TERC4 symbol encoder: three registered stages per lane on PIXEL_CLK.
// Streaming datapath with no handshake: one symbol per lane per cycle, fixed 3-cycle latency.
module tmds_lane_encoder #(
  parameter int NUM_CH           = 3,
  parameter bit CLR_DISP_ON_CTRL = 1'b1
) (
  input  logic                 PIXEL_CLK,
  input  logic                 RESET,
  input  logic [2:0]           MODE,
  input  logic [8*NUM_CH-1:0]  DATA,
  input  logic [2*NUM_CH-1:0]  CTRL,
  input  logic [4*NUM_CH-1:0]  AUX,
  output logic [10*NUM_CH-1:0] TMDS_DATA,
  output logic [NUM_CH-1:0]    DISP_ERR
);
  typedef enum logic [2:0] {
    MODE_CTRL  = 3'd0,
    MODE_VIDEO = 3'd1,
    MODE_VGB   = 3'd2,
    MODE_DATA  = 3'd3,
    MODE_DGB   = 3'd4
  } mode_e;

  localparam logic [9:0] TOK_C00 = 10'b1101010100;
  localparam logic [9:0] GB_EVEN = 10'b0011001101;
  localparam logic [9:0] GB_ODD  = 10'b1100110010;

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  // Stored already bit-reversed so that table bit q[0] sits in bit 0.
  function automatic logic [9:0] terc4(input logic [3:0] a);
    case (a)
      4'h0:    return 10'b0011100101;
      4'h1:    return 10'b1100011001;
      4'h2:    return 10'b0010011101;
      4'h3:    return 10'b0100011101;
      4'h4:    return 10'b1000111010;
      4'h5:    return 10'b0111100010;
      4'h6:    return 10'b0111000110;
      4'h7:    return 10'b0011110010;
      4'h8:    return 10'b0011001101;
      4'h9:    return 10'b1001110010;
      4'hA:    return 10'b0011100110;
      4'hB:    return 10'b0110001101;
      4'hC:    return 10'b0111000101;
      4'hD:    return 10'b1000111001;
      4'hE:    return 10'b1100011010;
      default: return 10'b1100001101;
    endcase
  endfunction

  mode_e mode_in, s1_mode, s2_mode;

  always_comb begin
    case (MODE)
      3'd1:    mode_in = MODE_VIDEO;
      3'd2:    mode_in = MODE_VGB;
      3'd3:    mode_in = MODE_DATA;
      3'd4:    mode_in = MODE_DGB;
      default: mode_in = MODE_CTRL;
    endcase
  end

  always_ff @(posedge PIXEL_CLK) begin
    if (RESET) begin
      s1_mode <= MODE_CTRL;
      s2_mode <= MODE_CTRL;
    end else begin
      s1_mode <= mode_in;
      s2_mode <= s1_mode;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    localparam bit ODD = (i % 2) == 1;

    logic [7:0]        d_in;
    logic [3:0]        n_d;
    logic              use_xnor;
    logic [7:0]        s1_d;
    logic              s1_xnor;
    logic [1:0]        s1_c, s2_c;
    logic [3:0]        s1_a, s2_a;
    logic [8:0]        qm, s2_qm;
    logic [3:0]        qm_n1, s2_n1;
    logic signed [4:0] cnt_q, cnt_nxt, diff;
    logic [9:0]        sym, tmds_q;
    logic              q8, disp_oor, err_q;

    assign d_in = DATA[8*i +: 8];

    always_comb begin
      n_d = '0;
      for (int k = 0; k < 8; k++) n_d = n_d + {3'b000, d_in[k]};
      use_xnor = (n_d > 4'd4) || ((n_d == 4'd4) && !d_in[0]);
    end

    always_comb begin
      qm    = '0;
      qm[0] = s1_d[0];
      for (int k = 1; k < 8; k++)
        qm[k] = s1_xnor ? ~(qm[k-1] ^ s1_d[k]) : (qm[k-1] ^ s1_d[k]);
      qm[8] = ~s1_xnor;
      qm_n1 = '0;
      for (int k = 0; k < 8; k++) qm_n1 = qm_n1 + {3'b000, qm[k]};
    end

    // Disparity math is modulo-32, matching the 5-bit two's complement counter.
    always_comb begin
      q8      = s2_qm[8];
      diff    = $signed({s2_n1, 1'b0}) - 5'sd8;
      cnt_nxt = cnt_q;
      sym     = TOK_C00;
      case (s2_mode)
        MODE_VIDEO: begin
          if ((cnt_q == 5'sd0) || (s2_n1 == 4'd4)) begin
            sym     = {~q8, q8, q8 ? s2_qm[7:0] : ~s2_qm[7:0]};
            cnt_nxt = q8 ? (cnt_q + diff) : (cnt_q - diff);
          end else if ((!cnt_q[4] && (s2_n1 > 4'd4)) || (cnt_q[4] && (s2_n1 < 4'd4))) begin
            sym     = {1'b1, q8, ~s2_qm[7:0]};
            cnt_nxt = cnt_q + (q8 ? 5'sd2 : 5'sd0) - diff;
          end else begin
            sym     = {1'b0, q8, s2_qm[7:0]};
            cnt_nxt = cnt_q - (q8 ? 5'sd0 : 5'sd2) + diff;
          end
        end
        MODE_VGB:  sym = ODD ? GB_ODD : GB_EVEN;
        MODE_DATA: sym = terc4(s2_a);
        MODE_DGB:  sym = (i == 0) ? terc4({2'b11, s2_c}) : GB_ODD;
        default:   sym = ctrl_token(s2_c);
      endcase
      if ((s2_mode != MODE_VIDEO) && CLR_DISP_ON_CTRL) cnt_nxt = '0;
      disp_oor = (cnt_nxt > 5'sd8) || (cnt_nxt < -5'sd8);
    end

    always_ff @(posedge PIXEL_CLK) begin
      if (RESET) begin
        s1_d    <= '0;
        s1_xnor <= 1'b0;
        s1_c    <= '0;
        s1_a    <= '0;
        s2_qm   <= '0;
        s2_n1   <= '0;
        s2_c    <= '0;
        s2_a    <= '0;
        cnt_q   <= '0;
        tmds_q  <= TOK_C00;
        err_q   <= 1'b0;
      end else begin
        s1_d    <= d_in;
        s1_xnor <= use_xnor;
        s1_c    <= CTRL[2*i +: 2];
        s1_a    <= AUX[4*i +: 4];
        s2_qm   <= qm;
        s2_n1   <= qm_n1;
        s2_c    <= s1_c;
        s2_a    <= s1_a;
        cnt_q   <= cnt_nxt;
        tmds_q  <= sym;
        err_q   <= err_q | disp_oor;
      end
    end

    assign TMDS_DATA[10*i +: 10] = tmds_q;
    assign DISP_ERR[i]           = err_q;
  end

endmodule
